// File: rtl/optical_flow_pkg.sv
// Types and widths shared by the optical-flow front end (window accumulator and flow solver).
package optical_flow_pkg;

    localparam int GRAD_WIDTH   = 10;
    localparam int ACCUM_WIDTH  = 32;
    localparam int FLOW_WIDTH   = 16;
    localparam int FRAC_BITS    = 8;
    localparam int NUM_PRODUCTS = 5;

    typedef logic [9:0] pixel_x_t;
    typedef logic [8:0] pixel_y_t;

    typedef logic signed [ACCUM_WIDTH-1:0] accum_t;
    typedef accum_t [NUM_PRODUCTS-1:0] product_vec_t;

    typedef struct packed {
        accum_t ixix;
        accum_t iyiy;
        accum_t ixiy;
        accum_t ixit;
        accum_t iyit;
    } grad_products_t;

    // Index order used everywhere a product is addressed by number: IxIx, IyIy, IxIy, IxIt, IyIt.
    function automatic product_vec_t products_to_vec(input grad_products_t p);
        product_vec_t v;
        v[0] = p.ixix;
        v[1] = p.iyiy;
        v[2] = p.ixiy;
        v[3] = p.ixit;
        v[4] = p.iyit;
        return v;
    endfunction

    function automatic grad_products_t vec_to_products(input product_vec_t v);
        grad_products_t p;
        p.ixix = v[0];
        p.iyiy = v[1];
        p.ixiy = v[2];
        p.ixit = v[3];
        p.iyit = v[4];
        return p;
    endfunction

endpackage

// File: rtl/product_line_buffer.sv
// Row-shift line buffer of gradient products: each write at column addr pushes the oldest row out.
// Reads return the contents from before the same-beat write.
module product_line_buffer
    import optical_flow_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int DEPTH = 320,
    parameter int AW    = 9
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [AW-1:0]             addr,
    input  grad_products_t            wr_data,
    output grad_products_t [ROWS-1:0] rd_data
);

    grad_products_t mem [ROWS][DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int r = 0; r < ROWS; r++) begin
                rd_data[r] <= mem[r][addr];
            end
            mem[0][addr] <= wr_data;
            for (int r = 1; r < ROWS; r++) begin
                mem[r][addr] <= mem[r-1][addr];
            end
        end
    end

endmodule

// File: rtl/window_accumulator.sv
// Sums the five gradient products over a WINDOW_SIZE x WINDOW_SIZE neighbourhood of a raster stream.
// Three register stages: products + line-buffer read, column sums, sliding horizontal window.
module window_accumulator #(
    parameter int GRAD_WIDTH  = optical_flow_pkg::GRAD_WIDTH,
    parameter int ACCUM_WIDTH = optical_flow_pkg::ACCUM_WIDTH,
    parameter int WINDOW_SIZE = 5,
    parameter int IMG_WIDTH   = 320
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [GRAD_WIDTH-1:0]  grad_ix,
    input  logic signed [GRAD_WIDTH-1:0]  grad_iy,
    input  logic signed [GRAD_WIDTH-1:0]  grad_it,
    input  logic                          grad_valid,
    input  optical_flow_pkg::pixel_x_t    pixel_x_in,
    input  optical_flow_pkg::pixel_y_t    pixel_y_in,
    output logic signed [ACCUM_WIDTH-1:0] sum_IxIx,
    output logic signed [ACCUM_WIDTH-1:0] sum_IyIy,
    output logic signed [ACCUM_WIDTH-1:0] sum_IxIy,
    output logic signed [ACCUM_WIDTH-1:0] sum_IxIt,
    output logic signed [ACCUM_WIDTH-1:0] sum_IyIt,
    output logic                          accum_valid,
    output optical_flow_pkg::pixel_x_t    pixel_x_out,
    output optical_flow_pkg::pixel_y_t    pixel_y_out
);
    import optical_flow_pkg::*;

    localparam int ROWS  = WINDOW_SIZE - 1;
    localparam int R     = (WINDOW_SIZE - 1) / 2;
    localparam int PW    = 2 * GRAD_WIDTH;
    localparam int LB_AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam pixel_x_t X_FIRST = pixel_x_t'(WINDOW_SIZE - 1);
    localparam pixel_y_t Y_FIRST = pixel_y_t'(WINDOW_SIZE - 1);
    localparam pixel_x_t X_OFS   = pixel_x_t'(R);
    localparam pixel_y_t Y_OFS   = pixel_y_t'(R);

    logic signed [PW-1:0] ix_w, iy_w, it_w;
    product_vec_t         prod_vec;
    product_vec_t         s1_prod;
    logic                 s1_valid, s2_valid, s2_in_window;
    pixel_x_t             s1_x, s2_x;
    pixel_y_t             s1_y, s2_y;
    grad_products_t [ROWS-1:0] row_data;
    product_vec_t         row_vec [ROWS];
    accum_t               sum_all [NUM_PRODUCTS];

    // Widen before multiplying so the products are exact at 2*GRAD_WIDTH bits.
    always_comb begin
        ix_w = PW'(grad_ix);
        iy_w = PW'(grad_iy);
        it_w = PW'(grad_it);
        prod_vec[0] = accum_t'(ix_w * ix_w);
        prod_vec[1] = accum_t'(iy_w * iy_w);
        prod_vec[2] = accum_t'(ix_w * iy_w);
        prod_vec[3] = accum_t'(ix_w * it_w);
        prod_vec[4] = accum_t'(iy_w * it_w);
    end

    product_line_buffer #(
        .ROWS  (ROWS),
        .DEPTH (IMG_WIDTH),
        .AW    (LB_AW)
    ) u_line_buffer (
        .clk     (clk),
        .we      (grad_valid),
        .addr    (pixel_x_in[LB_AW-1:0]),
        .wr_data (vec_to_products(prod_vec)),
        .rd_data (row_data)
    );

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_vec[r] = products_to_vec(row_data[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
            s2_valid <= 1'b0;
            s2_x     <= '0;
            s2_y     <= '0;
        end else begin
            s1_valid <= grad_valid;
            if (grad_valid) begin
                s1_prod <= prod_vec;
                s1_x    <= pixel_x_in;
                s1_y    <= pixel_y_in;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_x <= s1_x;
                s2_y <= s1_y;
            end
        end
    end

    // Rows above Y_FIRST read line-buffer data from an earlier frame, so they never reach the output.
    assign s2_in_window = (s2_x >= X_FIRST) && (s2_y >= Y_FIRST);

    for (genvar p = 0; p < NUM_PRODUCTS; p++) begin : g_prod
        accum_t col_next, col_q, run_next, run_q, sum_q;
        accum_t win_q [WINDOW_SIZE];

        always_comb begin
            col_next = s1_prod[p];
            for (int r = 0; r < ROWS; r++) begin
                col_next = col_next + row_vec[r][p];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                col_q <= '0;
            end else if (s1_valid) begin
                col_q <= col_next;
            end
        end

        // A new row restarts the window; win_q[WINDOW_SIZE-1] is the column sliding out.
        assign run_next = (s2_x == '0) ? col_q : run_q + col_q - win_q[WINDOW_SIZE-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                run_q <= '0;
                sum_q <= '0;
                for (int i = 0; i < WINDOW_SIZE; i++) begin
                    win_q[i] <= '0;
                end
            end else if (s2_valid) begin
                run_q    <= run_next;
                win_q[0] <= col_q;
                for (int i = 1; i < WINDOW_SIZE; i++) begin
                    win_q[i] <= (s2_x == '0) ? '0 : win_q[i-1];
                end
                if (s2_in_window) begin
                    sum_q <= run_next;
                end
            end
        end

        assign sum_all[p] = sum_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            accum_valid <= 1'b0;
            pixel_x_out <= '0;
            pixel_y_out <= '0;
        end else begin
            accum_valid <= s2_valid && s2_in_window;
            if (s2_valid && s2_in_window) begin
                pixel_x_out <= s2_x - X_OFS;
                pixel_y_out <= s2_y - Y_OFS;
            end
        end
    end

    assign sum_IxIx = sum_all[0];
    assign sum_IyIy = sum_all[1];
    assign sum_IxIy = sum_all[2];
    assign sum_IxIt = sum_all[3];
    assign sum_IyIt = sum_all[4];

endmodule

// File: tb/tb_window_accumulator.sv
// Bench for window_accumulator on a 16x8 frame: a direct 5x5 box-sum model feeds a scoreboard queue.
module tb_window_accumulator;
    import optical_flow_pkg::*;

    localparam int W = 16;
    localparam int H = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [9:0]   grad_ix, grad_iy, grad_it;
    logic                grad_valid;
    pixel_x_t            pixel_x_in;
    pixel_y_t            pixel_y_in;
    logic signed [31:0]  sum_IxIx, sum_IyIy, sum_IxIy, sum_IxIt, sum_IyIt;
    logic                accum_valid;
    pixel_x_t            pixel_x_out;
    pixel_y_t            pixel_y_out;

    window_accumulator #(
        .GRAD_WIDTH  (10),
        .ACCUM_WIDTH (32),
        .WINDOW_SIZE (5),
        .IMG_WIDTH   (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .grad_ix     (grad_ix),
        .grad_iy     (grad_iy),
        .grad_it     (grad_it),
        .grad_valid  (grad_valid),
        .pixel_x_in  (pixel_x_in),
        .pixel_y_in  (pixel_y_in),
        .sum_IxIx    (sum_IxIx),
        .sum_IyIy    (sum_IyIy),
        .sum_IxIy    (sum_IxIy),
        .sum_IxIt    (sum_IxIt),
        .sum_IyIt    (sum_IyIt),
        .accum_valid (accum_valid),
        .pixel_x_out (pixel_x_out),
        .pixel_y_out (pixel_y_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        longint s0, s1, s2, s3, s4;
        int     x;
        int     y;
        int     due;
    } exp_t;

    exp_t   sb[$];
    longint mp [5][H][W];
    int     strobes;
    int     first_cyc;
    int     t44;
    longint cap22 [5];
    longint cap73 [5];

    always @(negedge clk) begin : mon
        exp_t e;
        if (accum_valid === 1'b1) begin
            if (strobes == 0) first_cyc = cyc;
            strobes++;
            if (pixel_x_out == 2 && pixel_y_out == 2)
                cap22 = '{sum_IxIx, sum_IyIy, sum_IxIy, sum_IxIt, sum_IyIt};
            if (pixel_x_out == 7 && pixel_y_out == 3)
                cap73 = '{sum_IxIx, sum_IyIy, sum_IxIy, sum_IxIt, sum_IyIt};
            if (sb.size() == 0) begin
                check_val("unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                check_val("latency",  cyc, e.due);
                check_val("x_out",    pixel_x_out, e.x);
                check_val("y_out",    pixel_y_out, e.y);
                check_val("IxIx",     sum_IxIx, e.s0);
                check_val("IyIy",     sum_IyIy, e.s1);
                check_val("IxIy",     sum_IxIy, e.s2);
                check_val("IxIt",     sum_IxIt, e.s3);
                check_val("IyIt",     sum_IyIt, e.s4);
            end
        end
    end

    function automatic void push_expect(input int x, input int y);
        exp_t   e;
        longint s [5];
        for (int p = 0; p < 5; p++) begin
            s[p] = 0;
            for (int dy = 0; dy < 5; dy++)
                for (int dx = 0; dx < 5; dx++)
                    s[p] += mp[p][y-dy][x-dx];
        end
        e.s0 = s[0]; e.s1 = s[1]; e.s2 = s[2]; e.s3 = s[3]; e.s4 = s[4];
        e.x = x - 2;
        e.y = y - 2;
        e.due = cyc + 3;
        sb.push_back(e);
    endfunction

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        grad_valid = 1'b0;
    endtask

    task automatic beat(input int x, input int y, input int ix, input int iy, input int it,
                        input bit with_rst);
        @(posedge clk);
        #1;
        grad_valid = 1'b1;
        rst        = with_rst;
        pixel_x_in = pixel_x_t'(x);
        pixel_y_in = pixel_y_t'(y);
        grad_ix    = 10'(ix);
        grad_iy    = 10'(iy);
        grad_it    = 10'(it);
        if (!with_rst) begin
            mp[0][y][x] = longint'(ix) * ix;
            mp[1][y][x] = longint'(iy) * iy;
            mp[2][y][x] = longint'(ix) * iy;
            mp[3][y][x] = longint'(ix) * it;
            mp[4][y][x] = longint'(iy) * it;
            if (x >= 4 && y >= 4) push_expect(x, y);
            if (x == 4 && y == 4) t44 = cyc;
        end
    endtask

    // mode 0 constant, 1 ramp Ix=x, 2 random, 3 alternating +511/-512 rows
    task automatic run_frame(input int mode, input int gap_pct, input int c_ix, input int c_iy,
                             input int c_it, input int rst_x, input int rst_y);
        int ix, iy, it;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) idle_cycle();
                case (mode)
                    1:       begin ix = x; iy = 1; it = 0; end
                    2:       begin
                                 ix = int'($urandom_range(1023, 0)) - 512;
                                 iy = int'($urandom_range(1023, 0)) - 512;
                                 it = int'($urandom_range(1023, 0)) - 512;
                             end
                    3:       begin ix = (y % 2 == 0) ? 511 : -512; iy = ix; it = ix; end
                    default: begin ix = c_ix; iy = c_iy; it = c_it; end
                endcase
                if (x == rst_x && y == rst_y) begin
                    beat(x, y, ix, iy, it, 1'b1);
                    @(posedge clk);
                    #1;
                    sb.delete();
                    check_val("rst_valid", accum_valid, 0);
                    check_val("rst_IxIx",  sum_IxIx, 0);
                    check_val("rst_IyIt",  sum_IyIt, 0);
                    check_val("rst_x_out", pixel_x_out, 0);
                    check_val("rst_y_out", pixel_y_out, 0);
                    rst        = 1'b0;
                    grad_valid = 1'b0;
                    return;
                end
                beat(x, y, ix, iy, it, 1'b0);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        idle_cycle();
        while (sb.size() != 0 && n < 20) begin
            idle_cycle();
            n++;
        end
        repeat (4) idle_cycle();
        check_val("drain_queue_empty", sb.size(), 0);
    endtask

    int s_at;

    initial begin
        rst        = 1'b1;
        grad_valid = 1'b0;
        grad_ix    = '0;
        grad_iy    = '0;
        grad_it    = '0;
        pixel_x_in = '0;
        pixel_y_in = '0;
        strobes    = 0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_valid", accum_valid, 0);
        check_val("reset_IxIx",  sum_IxIx, 0);
        check_val("reset_IxIt",  sum_IxIt, 0);
        check_val("reset_x_out", pixel_x_out, 0);
        rst = 1'b0;

        strobes = 0;
        run_frame(0, 0, 2, 3, -1, -1, -1);
        drain();
        check_val("const_strobes",   strobes, 48);
        check_val("const_first_lat", first_cyc - t44, 3);
        check_val("const_IxIx", cap22[0], 100);
        check_val("const_IyIy", cap22[1], 225);
        check_val("const_IxIy", cap22[2], 150);
        check_val("const_IxIt", cap22[3], -50);
        check_val("const_IyIt", cap22[4], -75);

        run_frame(1, 0, 0, 0, 0, -1, -1);
        drain();
        check_val("ramp_IxIy_cx7", cap73[2], 175);
        check_val("ramp_IxIt_cx7", cap73[3], 0);

        strobes = 0;
        run_frame(2, 40, 0, 0, 0, -1, -1);
        drain();
        check_val("gaps_strobes", strobes, 48);

        run_frame(0, 0, -512, -512, -512, -1, -1);
        drain();
        for (int p = 0; p < 5; p++) check_val("extreme_sum", cap22[p], 6553600);

        run_frame(3, 0, 0, 0, 0, -1, -1);
        drain();

        strobes = 0;
        run_frame(0, 0, 1, 2, 3, 8, 5);
        s_at = strobes;
        repeat (6) idle_cycle();
        check_val("no_strobe_after_rst", strobes, s_at);
        strobes = 0;
        run_frame(0, 0, -3, 4, 5, -1, -1);
        drain();
        check_val("restart_strobes",   strobes, 48);
        check_val("restart_first_lat", first_cyc - t44, 3);

        run_frame(0, 0, 7, -7, 1, -1, -1);
        run_frame(0, 0, -2, 5, 9, -1, -1);
        drain();
        check_val("b2b_IxIy", cap22[2], -250);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
